// File: rtl/shift_arbiter.sv
// shift_arbiter: NUM_REQ requesters share one barrel shifter behind a single registered response slot.
// Define SHIFT_ARB_RR_EN for round-robin arbitration; the default build is fixed priority (lowest index wins).
module shift_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*32-1:0] req_in,
  input  logic [NUM_REQ*2-1:0]  req_sel,
  input  logic [NUM_REQ*5-1:0]  req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [31:0]           rsp_data
);

  localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned AMT_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   own;
  logic [IDX_W-1:0]   win;
  logic               any_valid;
  logic               slot_free;
  logic               grant;
  logic [DATA_W-1:0]  op;
  logic [SEL_W-1:0]   sel;
  logic [AMT_W-1:0]   amt;
  logic [DATA_W-1:0]  shift_out;

`ifdef SHIFT_ARB_RR_EN
  logic [IDX_W-1:0]   last;

  // Round-robin: scan from last+1; iterating downward lets the nearest candidate win.
  always_comb begin : arb
    int unsigned idx;
    win       = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      idx = (int unsigned'(last) + int unsigned'(k)) % NUM_REQ;
      if (req_valid[IDX_W'(idx)]) begin
        win       = IDX_W'(idx);
        any_valid = 1'b1;
      end
    end
  end
`else
  // Fixed priority: scanning downward leaves the lowest valid index as winner.
  always_comb begin : arb
    win       = '0;
    any_valid = 1'b0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[IDX_W'(i)]) begin
        win       = IDX_W'(i);
        any_valid = 1'b1;
      end
    end
  end
`endif

  // The slot can accept a new result when empty or when its owner is draining it this cycle.
  always_comb begin : grant_logic
    slot_free = (state == IDLE) || rsp_ready[own];
    grant     = any_valid && slot_free;
    req_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_ready[i] = grant && (win == IDX_W'(i));
    end
  end

  // Route the winner's operands to the shared shifter.
  always_comb begin : operand_mux
    op  = '0;
    sel = '0;
    amt = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (win == IDX_W'(i)) begin
        op  = req_in[i*DATA_W +: DATA_W];
        sel = req_sel[i*SEL_W +: SEL_W];
        amt = req_b[i*AMT_W +: AMT_W];
      end
    end
  end

  // Barrel shifter: 00 SRL, 01 SRA, 1x SLL.
  always_comb begin : shifter
    shift_out = '0;
    case (sel)
      2'b00:   shift_out = op >> amt;
      2'b01:   shift_out = DATA_W'($signed(op) >>> amt);
      default: shift_out = op << amt;
    endcase
  end

  // Response slot FSM; a grant always wins over a plain release so there is no bubble.
  always_ff @(posedge clk or negedge rst_n) begin : slot_fsm
    if (!rst_n) begin
      state     <= IDLE;
      own       <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
`ifdef SHIFT_ARB_RR_EN
      last      <= IDX_W'(NUM_REQ - 1);
`endif
    end else if (grant) begin
      state     <= HOLD;
      own       <= win;
      rsp_valid <= req_ready;
      rsp_data  <= shift_out;
`ifdef SHIFT_ARB_RR_EN
      last      <= win;
`endif
    end else if ((state == HOLD) && rsp_ready[own]) begin
      state     <= IDLE;
      rsp_valid <= '0;
    end
  end

endmodule

// File: doc/shift_arbiter.md
# shift_arbiter

Shares one `Barrel_shifter` instance between `NUM_REQ` requesters. Each requester uses a valid/ready request handshake and a valid/ready response handshake. The block arbitrates each cycle, drives the winner's operands through the combinational shifter, and registers the result into a single response slot. It sits between the execute-stage clients, such as the ALU shift path and the address/extract helper, and the shared shifter datapath.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..4.

Ports (the clock is `clk`; reset is `rst_n`, asynchronous, active-low):
- `clk`  in  1  — system clock; all state updates on the rising edge.
- `rst_n`  in  1  — asynchronous active-low reset.
- `req_valid`  in  `NUM_REQ`  — requester i has an operation pending.
- `req_ready`  out  `NUM_REQ`  — request i is accepted this cycle; one-hot or zero.
- `req_in`  in  `NUM_REQ*32`  — operand; slice i is bits [32i+31:32i].
- `req_sel`  in  `NUM_REQ*2`  — shift type: 00 SRL, 01 SRA, 10 SLL, 11 SLL.
- `req_b`  in  `NUM_REQ*5`  — shift amount, 0..31.
- `rsp_valid`  out  `NUM_REQ`  — result for requester i is held on `rsp_data`; one-hot or zero.
- `rsp_ready`  in  `NUM_REQ`  — requester i consumes the result.
- `rsp_data`  out  32  — registered shifter result; shared by all requesters.

## Operation
- State machine has two states: IDLE (result slot empty) and HOLD (slot full, owner `own` recorded).
- Slot is free when the state is IDLE, or when the state is HOLD and `rsp_ready[own]` is 1 in the same cycle.
- Arbitration:
  - Evaluated combinationally every cycle over `req_valid`.
  - A winner is granted only while the slot is free; `req_ready` is 1 only for the winner.
- On a grant (`req_valid[w] & req_ready[w]`):
  - Slice w of `req_in`/`req_sel`/`req_b` drives the shifter.
  - `rsp_data` <= shifter out; `own` <= w; `rsp_valid` <= one-hot(w); state -> HOLD.
- In HOLD with `rsp_ready[own]` = 1 and no grant: `rsp_valid` <= 0; state -> IDLE.
- In HOLD with `rsp_ready[own]` = 0: `rsp_data`, `rsp_valid` and `own` hold; all `req_ready` are 0.
- `rsp_ready` bits of non-owners are ignored.
- Shift semantics match `Barrel_shifter`:
  - SRA fills with bit 31 of the operand.
  - B = 0 returns the operand unchanged.
- Requester rule: while `req_valid[i]` = 1 and `req_ready[i]` = 0, requester i holds its operands stable and keeps valid asserted. The block assumes this and does not check it.
- Round-robin pointer `last` (see Configuration) updates to w on every grant.

## Timing
- Reset values:
  - `rsp_valid` = 0, `rsp_data` = 32'h0, `req_ready` = 0.
  - State = IDLE, `own` = 0, `last` = `NUM_REQ`-1.
- Latency: grant in cycle N → `rsp_valid` and `rsp_data` valid in cycle N+1.
- Throughput: one operation per cycle when the owner holds `rsp_ready` = 1. This covers back-to-back grants, including the same requester twice in a row.
- Simultaneous release and grant in the same cycle: the new result overwrites the slot. `rsp_valid` moves to the new owner with no bubble.
- Reset asserted mid-operation:
  - The pending result is discarded; outputs return to their reset values immediately (asynchronous).
  - No response is issued for the discarded operation.
- `req_ready` is combinational from `req_valid`, state and `rsp_ready`. `rsp_valid` and `rsp_data` are registered only.

## Configuration
- `SHIFT_ARB_RR_EN` defined (round-robin):
  - Priority search starts at `last`+1 modulo `NUM_REQ`.
  - Under continuous contention, every requester is granted at least once in any `NUM_REQ` consecutive grants.
- `SHIFT_ARB_RR_EN` undefined (fixed priority):
  - Lowest index wins.
  - `last` is not implemented.

## Test plan
- Reset, then req0 SRA with `req_in`=32'h8000_0000, B=4, `rsp_ready`=1 → cycle+1: `rsp_valid`=01, `rsp_data`=32'hF800_0000.
- req0 and req1 both valid, held for 4 cycles, `rsp_ready`=11, `SHIFT_ARB_RR_EN` defined → grant order 0,1,0,1. Without the macro → 0,0,0,0.
- req1 SLL with 32'h0000_00FF, B=8, `rsp_ready[1]`=0 for 3 cycles → `rsp_data`=32'h0000_FF00 held and all `req_ready`=0 during the stall; completes when `rsp_ready[1]` rises.
- Owner releases and req0 SRL (32'hF000_000F, B=31) is granted in the same cycle → next cycle `rsp_valid`=01, `rsp_data`=32'h0000_0001, with no idle cycle.
- B=0 on every `sel` value with 32'hA5A5_5A5A → `rsp_data`=32'hA5A5_5A5A.
- `rst_n` pulled low while HOLD with `rsp_valid`=10 → `rsp_valid`=0 and `rsp_data`=0 without a clock edge; after release, req0 is granted first.
